// File: rtl/rtx_mem_pkg.sv
// Shared definitions for the RIPTIDE-II SDRAM refill path.
// Contents: default bus geometry, refill sequencer state encoding, owner codes.
package rtx_mem_pkg;

  localparam int ADDR_W_DEF    = 24;
  localparam int DATA_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 4;

  // Owner of the current burst; also the meaning of the round-robin last_grant bit.
  localparam logic OWN_P = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_P_RD  = 3'd2,
    ST_D_RD  = 3'd3,
    ST_D_WR  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/refill_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant for the refill arbiter.
// Ports:
//   clk_i, n_reset_i       clock, async active-low reset
//   en_i                   arbitration allowed this cycle
//   req_p_i / req_d_i      program / data cache requests
//   grant_p_o / grant_d_o  combinational one-hot grant (only while en_i)
// On a tie the requester that was not granted last wins; last_grant resets
// to D so the first tie after reset goes to P.
module rr_arb2
  import rtx_mem_pkg::*;
(
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic en_i,
  input  logic req_p_i,
  input  logic req_d_i,
  output logic grant_p_o,
  output logic grant_d_o
);

  logic last_q;
  logic last_d;
  logic pick_d;

  assign pick_d    = req_d_i & (~req_p_i | (last_q == OWN_P));
  assign grant_d_o = en_i & pick_d;
  assign grant_p_o = en_i & req_p_i & ~pick_d;

  always_comb begin
    last_d = last_q;
    if (grant_p_o) begin
      last_d = OWN_P;
    end else if (grant_d_o) begin
      last_d = OWN_D;
    end
  end

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      last_q <= OWN_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/refill_arbiter.sv
// refill_arbiter: shares the single SDRAM controller port between the
// program-cache and data-cache refill engines. One line request is granted
// at a time, issued as one burst, and its beats are counted and steered.
// Ports:
//   p_*   program cache: req/addr in, ack/rdata/rvalid/done out (read only)
//   d_*   data cache: req/we/addr/wdata in, ack/wnext/rdata/rvalid/done out
//   mem_* SDRAM controller: req/we/addr/wdata out, ready/wnext/rdata/rvalid in
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no burst; round-robin arbitration between p_req and d_req
// ST_ISSUE | burst command held on mem_req until mem_ready
// ST_P_RD  | counting read beats for the program cache
// ST_D_RD  | counting read beats for the data cache
// ST_D_WR  | streaming d_wdata to the controller on mem_wnext
// ST_DONE  | owner's done pulse; back to idle next cycle
module refill_arbiter
  import rtx_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk_i,
  input  logic              n_reset_i,
  input  logic              p_req_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  output logic              p_ack_o,
  output logic [DATA_W-1:0] p_rdata_o,
  output logic              p_rvalid_o,
  output logic              p_done_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_wnext_o,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_rvalid_o,
  output logic              d_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_wnext_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i
);

  localparam int              CNT_W     = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                owner_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                p_ack_q, d_ack_q;
  logic                p_rvalid_q, d_rvalid_q;
  logic                p_done_q, d_done_q;
  logic [DATA_W-1:0]   p_rdata_q, d_rdata_q;
  logic                grant_p, grant_d;
  logic                last_beat;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .n_reset_i (n_reset_i),
    .en_i      (state_q == ST_IDLE),
    .req_p_i   (p_req_i),
    .req_d_i   (d_req_i),
    .grant_p_o (grant_p),
    .grant_d_o (grant_d)
  );

  // Terminal beat found by equality so the counter can simply wrap.
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_P;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      p_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      p_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      p_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      p_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      p_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      p_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_p) begin
            p_ack_q    <= 1'b1;
            owner_q    <= OWN_P;
            mem_we_q   <= 1'b0;
            mem_addr_q <= p_addr_i & LINE_MASK;
            mem_req_q  <= 1'b1;
            state_q    <= ST_ISSUE;
          end else if (grant_d) begin
            d_ack_q    <= 1'b1;
            owner_q    <= OWN_D;
            mem_we_q   <= d_we_i;
            mem_addr_q <= d_addr_i & LINE_MASK;
            mem_req_q  <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (owner_q == OWN_P) begin
              state_q <= ST_P_RD;
            end else if (mem_we_q) begin
              state_q <= ST_D_WR;
            end else begin
              state_q <= ST_D_RD;
            end
          end
        end
        ST_P_RD: begin
          if (mem_rvalid_i) begin
            p_rdata_q  <= mem_rdata_i;
            p_rvalid_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
            if (last_beat) begin
              p_done_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_D_RD: begin
          if (mem_rvalid_i) begin
            d_rdata_q  <= mem_rdata_i;
            d_rvalid_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
            if (last_beat) begin
              d_done_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_D_WR: begin
          if (mem_wnext_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              d_done_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write data flows straight through so the controller sees the beat the
  // cache is presenting in the same cycle it consumes it.
  assign mem_wdata_o = (state_q == ST_D_WR) ? d_wdata_i : '0;
  assign d_wnext_o   = (state_q == ST_D_WR) & mem_wnext_i;

  assign p_ack_o    = p_ack_q;
  assign d_ack_o    = d_ack_q;
  assign p_rvalid_o = p_rvalid_q;
  assign d_rvalid_o = d_rvalid_q;
  assign p_done_o   = p_done_q;
  assign d_done_o   = d_done_q;
  assign p_rdata_o  = p_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Shares the single SDRAM controller port between the program-cache and data-cache refill engines of the RIPTIDE-II SDRAM system.
- Accepts one line request at a time from either cache, grants it, and issues one burst command to the SDRAM controller.
- Counts data beats and steers read data back to the owning cache, signalling completion.
- Sits between the two cache controllers, whose misses drive p_cache_miss / d_cache_miss stalls on the core, and the SDRAM controller.

Parameters:
- ADDR_W, 24, word address width toward SDRAM.
- DATA_W, 16, data word width.
- BURST_LEN, 4, words per cache line. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- p_req  in  1  program-cache line fill request; held high until p_ack.
- p_addr  in  ADDR_W  program fill word address.
- p_ack  out  1  one-cycle pulse; request accepted.
- p_rdata  out  DATA_W  fill data.
- p_rvalid  out  1  p_rdata valid this cycle.
- p_done  out  1  one-cycle pulse after the last beat.
- d_req  in  1  data-cache request; held high until d_ack.
- d_we  in  1  1 = line writeback, 0 = line fill.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  writeback data for the current beat.
- d_wnext  out  1  current d_wdata consumed; cache advances to the next word.
- d_ack  out  1  one-cycle pulse; request accepted.
- d_rdata  out  DATA_W  fill data.
- d_rvalid  out  1  d_rdata valid.
- d_done  out  1  one-cycle pulse after the last beat.
- mem_req  out  1  burst command valid.
- mem_we  out  1  burst direction.
- mem_addr  out  ADDR_W  burst start address.
- mem_ready  in  1  SDRAM controller accepts the command this cycle.
- mem_wdata  out  DATA_W  write beat data.
- mem_wnext  in  1  SDRAM controller consumed mem_wdata.
- mem_rdata  in  DATA_W  read beat data.
- mem_rvalid  in  1  read beat valid.

Behaviour:
- States: IDLE, ISSUE, P_RD, D_RD, D_WR, DONE. A log2(BURST_LEN)-bit beat counter and a last_grant bit (0 = P, 1 = D).
- Reset (async, n_reset low) sets:
  - state IDLE, counter 0, last_grant 1;
  - all outputs 0, including mem_addr and both rdata buses.
- Reset mid-burst abandons the burst. The SDRAM controller shares n_reset.
- IDLE, arbitration:
  - only p_req: grant P;
  - only d_req: grant D;
  - both: grant the requester that is not last_grant (round-robin; first tie after reset goes to P).
- On grant:
  - pulse the matching ack;
  - register owner, direction (P is always read), and address with the low log2(BURST_LEN) bits cleared;
  - update last_grant;
  - move to ISSUE.
- ISSUE:
  - mem_req = 1 with registered mem_we and mem_addr, held stable until mem_ready;
  - on mem_req & mem_ready, go to P_RD, D_RD or D_WR with counter 0.
- P_RD / D_RD:
  - each mem_rvalid forwards mem_rdata to the owner's rdata bus, registered (1-cycle latency), with its rvalid;
  - counter increments.
  - The beat with counter = BURST_LEN-1 goes to DONE.
  - The non-owner rvalid is always 0.
- D_WR:
  - mem_wdata = d_wdata combinationally;
  - d_wnext = mem_wnext;
  - counter increments on mem_wnext; the last beat goes to DONE.
- DONE:
  - the owner's done pulses for one cycle; it is asserted in the same cycle as the final registered rvalid for reads;
  - return to IDLE.
  - A new grant is possible the next cycle, so there is a minimum 1-cycle bubble between bursts.
- mem_rvalid or mem_wnext outside the matching data state is ignored, and the counter is held.
- A requester dropping req before ack is legal; no grant occurs.
- A request arriving while busy waits. No queue; arbitration happens only in IDLE.
- Counter wraps naturally at BURST_LEN. Its terminal detection is by equality, not carry.

Decomposition:
- Shared package rtx_mem_pkg holds:
  - the state encoding constants;
  - owner encoding OWN_P = 0 / OWN_D = 1;
  - the default ADDR_W / DATA_W / BURST_LEN values.
- One natural sub-module: rr_arb2, the two-input round-robin grant with its last_grant register and req/grant outputs.
- Sequencer, counter and data steering stay in refill_arbiter.

Test Plan:
- Reset and idle:
  - stimulus: n_reset low, then high; no requests;
  - response: all outputs 0, mem_req stays 0, last_grant = 1.
- Single P fill:
  - stimulus: p_addr = 0x000123, mem_ready after 3 cycles, four mem_rvalid beats 0xA0..0xA3 with a gap;
  - response: p_ack pulse, mem_addr = 0x000120, mem_we = 0, p_rvalid ×4 with data 0xA0..0xA3, p_done pulse on the last, d_* silent.
- D writeback:
  - stimulus: d_we = 1, d_addr = 0x00FF07, mem_wnext on 4 non-consecutive cycles;
  - response: mem_addr = 0x00FF04, mem_we = 1, d_wnext mirrors mem_wnext, d_done after the 4th.
- Simultaneous requests:
  - stimulus: p_req and d_req raised together, three back-to-back line pairs;
  - response: grant order P, D, P, D, P, D, with a 1-idle-cycle gap between DONE and the next ack.
- Reset mid-burst:
  - stimulus: n_reset asserted after 2 of 4 read beats;
  - response: outputs immediately 0, state IDLE; a fresh request after release completes normally with 4 beats.
- Stray beats:
  - stimulus: mem_rvalid pulses in IDLE and in ISSUE;
  - response: no rvalid on either side, and the subsequent burst still needs exactly 4 beats.
